// File: rtl/cla_pkg.sv
// Shared constants and the per-stage pipeline record for the pipelined CLA subtractor.
// Record fields are sized for the widest supported operand; narrower builds use the low bits.
package cla_pkg;

    localparam int CLA_SLICE_W = 4;
    localparam int CLA_MAX_W   = 64;

    typedef struct packed {
        logic                 valid;
        logic                 op;
        logic                 carry;
        logic [CLA_MAX_W-1:0] a;
        logic [CLA_MAX_W-1:0] b;
        logic [CLA_MAX_W-1:0] d;
    } cla_stage_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead adder slice (generate/propagate form).
module cla4_slice
    import cla_pkg::*;
(
    input  logic [CLA_SLICE_W-1:0] a,
    input  logic [CLA_SLICE_W-1:0] b,
    input  logic                   ci,
    output logic [CLA_SLICE_W-1:0] s,
    output logic                   co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;

endmodule

// File: rtl/cla_pipe_subtractor.sv
// Pipelined WIDTH-bit subtractor, one 4-bit CLA slice per stage, global-stall valid/ready.
// Define CLA_PIPE_ADD_EN to add the in_op port (0 = subtract, 1 = add).
module cla_pipe_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef CLA_PIPE_ADD_EN
    input  logic             in_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_borrow,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NSTG = WIDTH / CLA_SLICE_W;
    localparam int MSB  = WIDTH - 1;

    cla_stage_t             st  [NSTG];
    cla_stage_t             nxt [NSTG];
    logic [CLA_SLICE_W-1:0] sa  [NSTG];
    logic [CLA_SLICE_W-1:0] sb  [NSTG];
    logic [CLA_SLICE_W-1:0] ss  [NSTG];
    logic                   sci [NSTG];
    logic                   sco [NSTG];

    logic             op_in;
    logic [WIDTH-1:0] b_eff;
    logic             stall;
    cla_stage_t       last;

`ifdef CLA_PIPE_ADD_EN
    assign op_in = in_op;
`else
    assign op_in = 1'b0;
`endif

    // b is stored already in its added form, so later stages never need the op to pick it.
    assign b_eff = op_in ? in_b : ~in_b;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign sa[k]  = in_a[CLA_SLICE_W-1:0];
            assign sb[k]  = b_eff[CLA_SLICE_W-1:0];
            assign sci[k] = ~op_in;
        end else begin : g_rest
            assign sa[k]  = st[k-1].a[k*CLA_SLICE_W +: CLA_SLICE_W];
            assign sb[k]  = st[k-1].b[k*CLA_SLICE_W +: CLA_SLICE_W];
            assign sci[k] = st[k-1].carry;
        end

        cla4_slice u_slice (
            .a  (sa[k]),
            .b  (sb[k]),
            .ci (sci[k]),
            .s  (ss[k]),
            .co (sco[k])
        );
    end

    always_comb begin
        nxt[0]                       = '0;
        nxt[0].valid                 = in_valid;
        nxt[0].op                    = op_in;
        nxt[0].a[WIDTH-1:0]          = in_a;
        nxt[0].b[WIDTH-1:0]          = b_eff;
        nxt[0].d[CLA_SLICE_W-1:0]    = ss[0];
        nxt[0].carry                 = sco[0];
        for (int k = 1; k < NSTG; k++) begin
            nxt[k]                                 = st[k-1];
            nxt[k].d[k*CLA_SLICE_W +: CLA_SLICE_W] = ss[k];
            nxt[k].carry                           = sco[k];
        end
    end

    assign stall    = st[NSTG-1].valid & ~out_ready;
    assign in_ready = ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) st[k] <= '0;
        end else if (!stall) begin
            for (int k = 0; k < NSTG; k++) st[k] <= nxt[k];
        end
    end

    assign last      = st[NSTG-1];
    assign out_valid = last.valid;
    assign out_d     = last.d[WIDTH-1:0];

    // Flags gated by valid so they read 0 out of reset; with b stored in added form,
    // one overflow rule covers both subtract and add.
    assign out_borrow = last.valid & (last.carry ~^ last.op);
    assign out_ovf    = last.valid & (last.a[MSB] == last.b[MSB]) & (last.d[MSB] != last.a[MSB]);
    assign out_zero   = last.valid & ~|out_d;

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// Directed and small streamed checks for cla_pipe_subtractor (WIDTH=16).
module tb_cla_pipe_subtractor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_d;
    logic        out_borrow;
    logic        out_ovf;
    logic        out_zero;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    cla_pipe_subtractor #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
`ifdef CLA_PIPE_ADD_EN
        .in_op      (in_op),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_d      (out_d),
        .out_borrow (out_borrow),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic op, input logic [15:0] exp_d, input logic exp_bor,
                           input logic exp_ovf, input logic exp_zero);
        int cycles;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick;
        in_valid = 1'b0;
        cycles   = 1;
        while (!out_valid && cycles < 20) begin
            tick;
            cycles++;
        end
        check({tag, "_latency"}, cycles, 4);
        check({tag, "_d"},       out_d, exp_d);
        check({tag, "_borrow"},  out_borrow, exp_bor);
        check({tag, "_ovf"},     out_ovf, exp_ovf);
        check({tag, "_zero"},    out_zero, exp_zero);
    endtask

    logic [15:0] sa_q [$];
    logic [15:0] sb_q [$];
    logic [15:0] exp_q [$];
    logic [2:0]  expf_q [$];

    task automatic stream_test;
        logic [15:0] pa [20];
        logic [15:0] pb [20];
        int idx;
        int got;
        int sia, sib, sd;
        logic [15:0] held_d;
        logic [2:0]  held_f;
        logic [15:0] ed;
        logic [2:0]  ef;
        for (int i = 0; i < 20; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
        end
        pa[3] = 16'h8000; pb[3] = 16'h7FFF;
        pa[4] = 16'h4321; pb[4] = 16'h4321;
        idx = 0;
        got = 0;
        held_d = '0;
        held_f = '0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            out_ready = !(cyc >= 8 && cyc <= 10);
            in_valid  = (idx < 20);
            if (idx < 20) begin
                in_a = pa[idx];
                in_b = pb[idx];
            end
            in_op = 1'b0;
            #1;
            if (cyc >= 8 && cyc <= 10) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                if (cyc == 8) begin
                    held_d = out_d;
                    held_f = {out_borrow, out_ovf, out_zero};
                end else begin
                    check("stall_hold_d", out_d, held_d);
                    check("stall_hold_flags", {out_borrow, out_ovf, out_zero}, held_f);
                end
            end
            if (in_valid && in_ready) begin
                sia = int'({{16{in_a[15]}}, in_a});
                sib = int'({{16{in_b[15]}}, in_b});
                sd  = sia - sib;
                ed  = in_a - in_b;
                ef  = {(in_a < in_b), (sd > 32767 || sd < -32768), (ed == 16'h0)};
                exp_q.push_back(ed);
                expf_q.push_back(ef);
                idx++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 1, 0);
                end else begin
                    ed = exp_q.pop_front();
                    ef = expf_q.pop_front();
                    check("stream_d", out_d, ed);
                    check("stream_flags", {out_borrow, out_ovf, out_zero}, ef);
                end
                got++;
            end
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, 20);
        check("stream_leftover", exp_q.size(), 0);
    endtask

    initial begin
        int stale;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_d",     out_d, 0);
        check("rst_flags",     {out_borrow, out_ovf, out_zero}, 0);
        rst = 1'b0;
        tick;

        run_one("sub_basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_one("sub_under",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_one("sub_zero",   16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_one("sub_ovf_neg", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

        tick;
        stream_test();
        tick;
        tick;

        // three operations in flight, then a one-cycle reset
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = 16'h1111; in_b = 16'h0001; tick;
        in_a = 16'h2222; in_b = 16'h0002; tick;
        in_a = 16'h3333; in_b = 16'h0003; tick;
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_flush_valid", out_valid, 0);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid) stale++;
        end
        check("rst_flush_stale", stale, 0);
        run_one("post_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

`ifdef CLA_PIPE_ADD_EN
        tick;
        run_one("add_ovf",  16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
`endif

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/cla_pipe_subtractor.md
# cla_pipe_subtractor

Pipelined WIDTH-bit subtractor built from 4-bit carry-look-ahead slices, one slice per pipeline stage. Computes A − B as A + ~B + 1 with a registered carry between stages. Each stage boundary is pipelined, so the block accepts one operation per cycle at full clock rate. It is the subtract-side counterpart of the team's 4-bit CLA adder and sits in datapaths that need difference, borrow and signed-overflow flags behind a valid/ready handshake.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4; NSTG = WIDTH/4.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  minuend.
- in_b  input  WIDTH  subtrahend.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_d  output  WIDTH  in_a − in_b, modulo 2^WIDTH.
- out_borrow  output  1  1 when unsigned in_a < in_b.
- out_ovf  output  1  signed two's-complement overflow.
- out_zero  output  1  out_d == 0.

## Operation
- Stage k (0..NSTG−1) computes difference bits [4k+3:4k] with one 4-bit CLA slice.
  - Stage 0 carry-in is constant 1.
  - Stage k>0 takes the carry registered by stage k−1.
- Operands are skewed:
  - Slice k of in_a and ~in_b is delayed k cycles, so it arrives with its carry.
  - Completed low result nibbles are carried forward until the last stage.
- Each stage holds a valid bit.
- Final stage:
  - out_borrow = ~carry_out of slice NSTG−1.
  - out_ovf = (a[MSB] ≠ b[MSB]) & (d[MSB] ≠ a[MSB]), using the delayed MSBs.
  - out_zero = NOR of all out_d bits.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, all stage registers hold (global stall). Bubbles are not compressed.
- out_d and all flags are held stable while out_valid=1 and out_ready=0.
- in_valid=0 inserts a bubble: the stage valid bit is cleared and data is don't-care.

## Timing
- Latency: an operand accepted in cycle t appears with out_valid=1 in cycle t+NSTG (4 for WIDTH=16), when no stall occurs.
- Throughput: one result per cycle while out_ready=1.
- Reset values: in_ready=1; out_valid=0; out_d=0; out_borrow=0; out_ovf=0; out_zero=0; all internal valid bits 0.
- Reset mid-operation: every in-flight operation is discarded. No output is produced for them, and the first accepted operand after rst deasserts is the first result.
- in_ready depends combinationally on out_ready. This is the only comb path from an input to an output.
- Simultaneous accept-in and accept-out in the same cycle is legal; the pipeline advances one stage.

## Configuration
- CLA_PIPE_ADD_EN defined:
  - Adds port in_op (input, 1): 0 = subtract, 1 = add.
  - The op travels with the operand.
  - Stage 0 carry-in becomes ~in_op, and B is inverted only when in_op=0.
  - out_borrow then reports ~carry_out for subtract and carry_out for add.
  - out_ovf uses the add rule: (a[MSB] = b[MSB]) & (d[MSB] ≠ a[MSB]).
- CLA_PIPE_ADD_EN undefined: no in_op port; the block only subtracts.

## Structure
- Shared package cla_pkg holds:
  - the slice width constant CLA_SLICE_W = 4;
  - the typedef of the per-stage record (valid, a/b skew fields, partial result, carry, op).
- Sub-module cla4_slice: combinational 4-bit generate/propagate look-ahead, with ports a[3:0], b[3:0], ci → s[3:0], co.
  - Instantiated NSTG times inside a generate loop.
- Top level contains only the stage registers, skew registers, flag logic and handshake.

## Test plan
- 0x1234 − 0x0234 → out_d=0x1000, borrow=0, ovf=0, zero=0; out_valid rises exactly 4 cycles after accept.
- 0x0000 − 0x0001 → out_d=0xFFFF, borrow=1, ovf=0.
- 0x8000 − 0x0001 → out_d=0x7FFF, ovf=1, borrow=0; then 0x5555 − 0x5555 → out_d=0, zero=1.
- Back-to-back stream of 20 random pairs:
  - hold out_ready=0 for 3 cycles mid-stream → in_ready=0 during the stall, outputs held stable, no result lost or duplicated;
  - results are in order and match a reference model.
- Assert rst for 1 cycle while 3 operations are in flight → out_valid=0 next cycle, no stale results afterwards; next operand 0x0010 − 0x0001 → 0x000F.
- With CLA_PIPE_ADD_EN: in_op=1, 0x7FFF + 0x0001 → out_d=0x8000, ovf=1, borrow(carry)=0; 0xFFFF + 0x0001 → out_d=0, carry=1, zero=1.
